// File: rtl/fp_sqrt_pkg.sv
// Shared constants and state encoding for the
// single-precision square root engine.
package fp_sqrt_pkg;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  localparam int EXP_BIAS = 127;
  localparam int ITER_COUNT = 25;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    ROUND,
    DONE
  } state_t;

endpackage

// File: rtl/fp_sqrt_step.sv
// One restoring square-root step: shifts in two
// radicand bits and tries subtracting 4*root+1.
module fp_sqrt_step #(
  parameter int QW = 25
) (
  input  logic [QW:0]   rem,
  input  logic [QW-1:0] root,
  input  logic [1:0]    bits,
  output logic [QW:0]   rem_next,
  output logic          root_bit,
  output logic          neg
);

  logic [QW+2:0] shifted;
  logic [QW+2:0] sub;
  logic          ge;

  assign shifted  = {rem, bits};
  assign sub      = {1'b0, root, 2'b01};
  assign ge       = shifted >= sub;
  assign rem_next = ge ? (QW+1)'(shifted - sub)
                       : shifted[QW:0];
  assign root_bit = ge;
  assign neg      = ~ge;

endmodule

// File: rtl/fp_sqrt_core.sv
// Iterative IEEE-754 single sqrt: one root bit per
// cycle, round-to-nearest, special-case bypass.
module fp_sqrt_core
  import fp_sqrt_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int EXP_WIDTH  = 8,
  parameter int MANT_WIDTH = 23,
  parameter int EXP_BIAS   = fp_sqrt_pkg::EXP_BIAS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] operand_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] norm_result_o,
  output logic [DATA_WIDTH-1:0] special_result_o,
  output logic                  special_sel_o
);

  localparam int QW = MANT_WIDTH + 2;
  localparam int RW = 2 * QW;

  state_t                state;
  logic [4:0]            cnt;
  logic [RW-1:0]         rad;
  logic [QW:0]           rem;
  logic [QW-1:0]         q;
  logic [EXP_WIDTH-1:0]  exp_q;

  logic                  sgn;
  logic [EXP_WIDTH-1:0]  exp_f;
  logic [MANT_WIDTH-1:0] man_f;
  logic signed [EXP_WIDTH:0] e_unb;
  logic signed [EXP_WIDTH:0] e_half;
  logic [EXP_WIDTH-1:0]  exp_res;
  logic [RW-1:0]         rad_init;

  assign {sgn, exp_f, man_f} = operand_i;
  assign e_unb  = $signed({1'b0, exp_f})
                - $signed((EXP_WIDTH+1)'(EXP_BIAS));
  assign e_half = e_unb >>> 1;
  assign exp_res = EXP_WIDTH'(e_half
                 + (EXP_WIDTH+1)'(EXP_BIAS));

  // Odd exponents take one extra shift so the root
  // always lands in [2^24, 2^25).
  assign rad_init = e_unb[0]
    ? (RW'({1'b1, man_f}) << (QW + 1))
    : (RW'({1'b1, man_f}) << QW);

  logic c_zero, c_inf, c_norm, c_qnan;
  logic                  spec_sel;
  logic [DATA_WIDTH-1:0] spec_val;

  assign c_zero = ~|exp_f;
  assign c_inf  = (&exp_f) & ~(|man_f) & ~sgn;
  assign c_norm = ~sgn & (|exp_f) & ~(&exp_f);
  assign c_qnan = ~(c_zero | c_inf | c_norm);

  always_comb begin
    spec_sel = 1'b1;
    spec_val = '0;
    unique case (1'b1)
      c_zero: spec_val = {sgn, {(DATA_WIDTH-1){1'b0}}};
      c_inf:  spec_val = PINF;
      c_qnan: spec_val = QNAN;
      c_norm: spec_sel = 1'b0;
      default: spec_sel = 1'b1;
    endcase
  end

  logic [QW:0] rem_next;
  logic        root_bit;
  logic        neg;

  fp_sqrt_step #(.QW(QW)) u_step (
    .rem      (rem),
    .root     (q),
    .bits     (rad[RW-1:RW-2]),
    .rem_next (rem_next),
    .root_bit (root_bit),
    .neg      (neg)
  );

  a_step: assert property (
    @(posedge clk_i) root_bit != neg);

  logic                  carry;
  logic [MANT_WIDTH-1:0] frac;
  logic [EXP_WIDTH-1:0]  exp_out;

  // All-ones root rounds up to the next binade.
  assign carry   = &q;
  assign frac    = q[MANT_WIDTH:1]
                 + MANT_WIDTH'(q[0]);
  assign exp_out = exp_q + EXP_WIDTH'(carry);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      cnt              <= '0;
      rad              <= '0;
      rem              <= '0;
      q                <= '0;
      exp_q            <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      norm_result_o    <= '0;
      special_result_o <= '0;
      special_sel_o    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            busy_o <= 1'b1;
            if (spec_sel) begin
              special_result_o <= spec_val;
              special_sel_o    <= 1'b1;
              norm_result_o    <= '0;
              done_o           <= 1'b1;
              state            <= DONE;
            end else begin
              rad   <= rad_init;
              rem   <= '0;
              q     <= '0;
              cnt   <= 5'(ITER_COUNT - 1);
              exp_q <= exp_res;
              state <= ITER;
            end
          end
        end
        ITER: begin
          rad <= rad << 2;
          rem <= rem_next;
          q   <= {q[QW-2:0], root_bit};
          if (cnt == '0) state <= ROUND;
          else cnt <= cnt - 5'd1;
        end
        ROUND: begin
          norm_result_o    <= {1'b0, exp_out, frac};
          special_result_o <= '0;
          special_sel_o    <= 1'b0;
          done_o           <= 1'b1;
          state            <= DONE;
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sqrt_core.sv
// Table-driven bench for fp_sqrt_core with a
// scoreboard queue checked on every done_o.
module tb_fp_sqrt_core;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] operand_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] norm_result_o;
  logic [31:0] special_result_o;
  logic        special_sel_o;

  fp_sqrt_core dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .operand_i        (operand_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .norm_result_o    (norm_result_o),
    .special_result_o (special_result_o),
    .special_sel_o    (special_sel_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic        sel;
    int          lat;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        sel;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[17];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               name, act, req);
    end
  endtask

  always @(negedge clk_i) begin : monitor
    exp_t e;
    if (!rst_i && done_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done_o=1 want 0");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_sel"}, 32'(special_sel_o),
            32'(e.sel));
        chk({e.name, "_res"},
            e.sel ? special_result_o : norm_result_o,
            e.res);
      end
    end
  end

  task automatic wait_done(input string name,
                           input int lat);
    int n;
    n = 1;
    while (!done_o && n < 60) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk({name, "_lat"}, 32'(n), 32'(lat));
  endtask

  task automatic run(input vec_t v);
    sb.push_back('{v.res, v.sel, v.name});
    start_i   = 1'b1;
    operand_i = v.op;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done(v.name, v.lat);
    @(posedge clk_i); #1;
    chk({v.name, "_idle_done"}, 32'(done_o), 32'd0);
    chk({v.name, "_idle_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    tbl[0]  = '{32'h40800000, 32'h40000000, 1'b0, 27, "sqrt4"};
    tbl[1]  = '{32'h40000000, 32'h3FB504F3, 1'b0, 27, "sqrt2"};
    tbl[2]  = '{32'h3E800000, 32'h3F000000, 1'b0, 27, "sqrt025"};
    tbl[3]  = '{32'h41100000, 32'h40400000, 1'b0, 27, "sqrt9"};
    tbl[4]  = '{32'h3F800000, 32'h3F800000, 1'b0, 27, "sqrt1"};
    tbl[5]  = '{32'h41800000, 32'h40800000, 1'b0, 27, "sqrt16"};
    tbl[6]  = '{32'h40400000, 32'h3FDDB3D7, 1'b0, 27, "sqrt3"};
    tbl[7]  = '{32'h7F7FFFFF, 32'h5F7FFFFF, 1'b0, 27, "sqrtmax"};
    tbl[8]  = '{32'hBF800000, 32'h7FC00000, 1'b1, 1, "neg1"};
    tbl[9]  = '{32'h7F800000, 32'h7F800000, 1'b1, 1, "pinf"};
    tbl[10] = '{32'h80000000, 32'h80000000, 1'b1, 1, "nzero"};
    tbl[11] = '{32'h00000001, 32'h00000000, 1'b1, 1, "denorm"};
    tbl[12] = '{32'h7FA00000, 32'h7FC00000, 1'b1, 1, "nan"};
    tbl[13] = '{32'hFF800000, 32'h7FC00000, 1'b1, 1, "ninf"};
    tbl[14] = '{32'h00000000, 32'h00000000, 1'b1, 1, "pzero"};
    tbl[15] = '{32'h80000001, 32'h80000000, 1'b1, 1, "ndenorm"};
    tbl[16] = '{32'h00800000, 32'h20000000, 1'b0, 27, "minnorm"};

    rst_i     = 1'b1;
    start_i   = 1'b0;
    operand_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_norm", norm_result_o, 32'd0);
    chk("rst_spec", special_result_o, 32'd0);
    chk("rst_sel", 32'(special_sel_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    for (int i = 0; i < 17; i++) run(tbl[i]);

    // second start mid-iteration must be dropped
    sb.push_back('{32'h40000000, 1'b0, "ignore"});
    start_i   = 1'b1;
    operand_i = 32'h40800000;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (n = 1; n < 10; n++) begin
      @(posedge clk_i); #1;
    end
    start_i   = 1'b1;
    operand_i = 32'h41100000;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n++;
    while (!done_o && n < 60) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("ignore_lat", 32'(n), 32'd27);
    repeat (40) @(posedge clk_i);
    #1;

    // reset in the middle of an iteration
    start_i   = 1'b1;
    operand_i = 32'h40800000;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (11) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    chk("mid_rst_done", 32'(done_o), 32'd0);
    chk("mid_rst_norm", norm_result_o, 32'd0);
    chk("mid_rst_spec", special_result_o, 32'd0);
    chk("mid_rst_sel", 32'(special_sel_o), 32'd0);
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk_i); #1;
      if (done_o) seen = 1'b1;
    end
    chk("mid_rst_no_done", 32'(seen), 32'd0);
    run('{32'h41100000, 32'h40400000, 1'b0, 27, "after_rst"});

    // back-to-back with start held through DONE
    sb.push_back('{32'h40000000, 1'b0, "b2b_a"});
    start_i   = 1'b1;
    operand_i = 32'h40800000;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_done("b2b_a", 27);
    sb.push_back('{32'h3FB504F3, 1'b0, "b2b_b"});
    start_i   = 1'b1;
    operand_i = 32'h40000000;
    @(posedge clk_i); #1;
    chk("b2b_done_ign", 32'(busy_o), 32'd0);
    chk("b2b_hold_idle", norm_result_o, 32'h40000000);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk("b2b_accept", 32'(busy_o), 32'd1);
    seen = 1'b0;
    n = 1;
    while (!done_o && n < 60) begin
      if (norm_result_o !== 32'h40000000) seen = 1'b1;
      @(posedge clk_i); #1;
      n++;
    end
    chk("b2b_b_lat", 32'(n), 32'd27);
    chk("b2b_stable", 32'(seen), 32'd0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("b2b_hold_after", norm_result_o, 32'h3FB504F3);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
